// File: rtl/npu_buf_pkg.sv
// Shared definitions for the NPU activation buffers: bank ownership states
// and the sizing helpers used to derive strobe width and bank depth.
package npu_buf_pkg;

  localparam logic BANK_STATE_FILL  = 1'b0;
  localparam logic BANK_STATE_DRAIN = 1'b1;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int bank_depth(input int bank_kb, input int data_width);
    return (bank_kb * 1024 * 8) / data_width;
  endfunction

endpackage

// File: rtl/activation_buffer_ring_if.sv
// Producer/consumer bus of the activation ring buffer; master is the
// DMA/PE side, slave is the buffer itself.
interface activation_buffer_ring_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 13,
  parameter int BANK_W     = 1
);
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic                    wr_commit;
  logic                    wr_ready;
  logic [BANK_W-1:0]       wr_bank;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    rd_release;
  logic                    rd_ready;
  logic [BANK_W-1:0]       rd_bank;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic [BANK_W:0]         full_count;
  logic                    err_overflow;
  logic                    err_underflow;

  modport master (
    output wr_en, wr_addr, wr_data, wr_strb, wr_commit,
    output rd_en, rd_addr, rd_release,
    input  wr_ready, wr_bank, rd_ready, rd_bank, rd_data, rd_valid,
    input  full_count, err_overflow, err_underflow
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_strb, wr_commit,
    input  rd_en, rd_addr, rd_release,
    output wr_ready, wr_bank, rd_ready, rd_bank, rd_data, rd_valid,
    output full_count, err_overflow, err_underflow
  );
endinterface

// File: rtl/act_ring_ctrl.sv
// Bank ownership control: fill/drain pointers, committed bank count,
// registered ready flags, request acceptance and sticky error flags.
module act_ring_ctrl
  import npu_buf_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_commit,
  input  logic              rd_en,
  input  logic              rd_release,
  output logic              wr_ready,
  output logic              rd_ready,
  output logic [BANK_W-1:0] wr_bank,
  output logic [BANK_W-1:0] rd_bank,
  output logic [BANK_W:0]   full_count,
  output logic              err_overflow,
  output logic              err_underflow,
  output logic              wr_accept,
  output logic              rd_accept
);

  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [BANK_W:0]   ALL_FULL  = (BANK_W + 1)'(NUM_BANKS);

  logic              wr_ready_reg, rd_ready_reg;
  logic [BANK_W-1:0] wr_bank_reg, wr_bank_next;
  logic [BANK_W-1:0] rd_bank_reg, rd_bank_next;
  logic [BANK_W:0]   full_count_reg, full_count_next;
  logic              err_overflow_reg, err_underflow_reg;
  logic              commit_accept, release_accept;

  // Accepts are gated by rst so nothing reaches memory during reset.
  always_comb begin
    wr_accept      = wr_en & wr_ready_reg & ~rst;
    rd_accept      = rd_en & rd_ready_reg & ~rst;
    commit_accept  = wr_commit & wr_ready_reg;
    release_accept = rd_release & rd_ready_reg;

    full_count_next = full_count_reg;
    if (commit_accept && !release_accept)
      full_count_next = full_count_reg + 1'b1;
    else if (release_accept && !commit_accept)
      full_count_next = full_count_reg - 1'b1;

    wr_bank_next = wr_bank_reg;
    if (commit_accept)
      wr_bank_next = (wr_bank_reg == LAST_BANK) ? '0 : wr_bank_reg + 1'b1;

    rd_bank_next = rd_bank_reg;
    if (release_accept)
      rd_bank_next = (rd_bank_reg == LAST_BANK) ? '0 : rd_bank_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_reg       <= '0;
      rd_bank_reg       <= '0;
      full_count_reg    <= '0;
      wr_ready_reg      <= 1'b1;
      rd_ready_reg      <= 1'b0;
      err_overflow_reg  <= 1'b0;
      err_underflow_reg <= 1'b0;
    end else begin
      wr_bank_reg       <= wr_bank_next;
      rd_bank_reg       <= rd_bank_next;
      full_count_reg    <= full_count_next;
      wr_ready_reg      <= (full_count_next < ALL_FULL);
      rd_ready_reg      <= (full_count_next != '0);
      err_overflow_reg  <= err_overflow_reg  | ((wr_en | wr_commit) & ~wr_ready_reg);
      err_underflow_reg <= err_underflow_reg | ((rd_en | rd_release) & ~rd_ready_reg);
    end
  end

  assign wr_ready      = wr_ready_reg;
  assign rd_ready      = rd_ready_reg;
  assign wr_bank       = wr_bank_reg;
  assign rd_bank       = rd_bank_reg;
  assign full_count    = full_count_reg;
  assign err_overflow  = err_overflow_reg;
  assign err_underflow = err_underflow_reg;

endmodule

// File: rtl/activation_buffer_ring.sv
// Multi-bank activation ring buffer: byte-strobed storage array addressed
// {bank, addr} with a two-stage registered read pipeline.
module activation_buffer_ring
  import npu_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_BANKS  = 2,
  parameter int BANK_KB    = 128,
  parameter int BANK_DEPTH = bank_depth(BANK_KB, DATA_WIDTH),
  parameter int ADDR_WIDTH = $clog2(BANK_DEPTH),
  parameter int BANK_W     = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
  input logic clk,
  input logic rst,
  activation_buffer_ring_if.slave bus
);

  localparam int STRB_W    = strb_width(DATA_WIDTH);
  localparam int MEM_DEPTH = NUM_BANKS * BANK_DEPTH;
  localparam int IDX_W     = BANK_W + ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [BANK_W-1:0]     wr_bank, rd_bank;
  logic                  wr_accept, rd_accept;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] rd_word_reg;
  logic                  s1_valid_reg;
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  rd_valid_reg;

  act_ring_ctrl #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (bus.wr_en),
    .wr_commit     (bus.wr_commit),
    .rd_en         (bus.rd_en),
    .rd_release    (bus.rd_release),
    .wr_ready      (bus.wr_ready),
    .rd_ready      (bus.rd_ready),
    .wr_bank       (wr_bank),
    .rd_bank       (rd_bank),
    .full_count    (bus.full_count),
    .err_overflow  (bus.err_overflow),
    .err_underflow (bus.err_underflow),
    .wr_accept     (wr_accept),
    .rd_accept     (rd_accept)
  );

  assign wr_idx = {wr_bank, bus.wr_addr};
  assign rd_idx = {rd_bank, bus.rd_addr};

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.wr_strb[b])
          mem[wr_idx][b*8 +: 8] <= bus.wr_data[b*8 +: 8];
      end
    end
  end

  // Stage 1 data register stays unreset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rd_accept)
      rd_word_reg <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      s1_valid_reg <= rd_accept;
      rd_valid_reg <= s1_valid_reg;
      if (s1_valid_reg)
        rd_data_reg <= rd_word_reg;
    end
  end

  assign bus.wr_bank  = wr_bank;
  assign bus.rd_bank  = rd_bank;
  assign bus.rd_data  = rd_data_reg;
  assign bus.rd_valid = rd_valid_reg;

endmodule
